// File: rtl/chunked_sub_unit.sv
// rtl/chunked_sub_unit.sv - multi-cycle W-bit unsigned subtractor, CHUNK bits per clock, valid/ready on both sides
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module chunked_sub_unit #(
    parameter int W     = 64,
    parameter int CHUNK = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow
`ifdef SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int N    = W / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [IDXW-1:0] idx;
    logic            carry_reg;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             last_chunk;
    logic             accept;

    // a - b as a + ~b + 1: the initial carry of 1 supplies the +1.
    always_comb begin
        a_chunk    = a_reg[int'(idx) * CHUNK +: CHUNK];
        b_chunk    = b_reg[int'(idx) * CHUNK +: CHUNK];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{CHUNK{1'b0}}, carry_reg};
        last_chunk = (idx == LAST_IDX);
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_ready && in_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = RUN;
            RUN:  if (last_chunk) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            carry_reg <= 1'b1;
            diff      <= '0;
            borrow    <= 1'b0;
`ifdef SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                idx       <= '0;
                carry_reg <= 1'b1;
                diff      <= '0;
            end else if (state_q == RUN) begin
                diff[int'(idx) * CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                carry_reg <= chunk_sum[CHUNK];
                idx       <= last_chunk ? '0 : idx + 1'b1;
                if (last_chunk) begin
                    borrow <= ~chunk_sum[CHUNK];
`ifdef SUB_OVF_EN
                    // Top result bit is the MSB of the final chunk being written now.
                    ovf <= (a_reg[W-1] != b_reg[W-1]) && (chunk_sum[CHUNK-1] != a_reg[W-1]);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_sub_unit.sv
// tb/tb_chunked_sub_unit.sv - scoreboard bench for chunked_sub_unit (CHUNK=16 and CHUNK=W instances)
module tb_chunked_sub_unit;

    logic        clk;
    logic        rst;
    logic [63:0] a;
    logic [63:0] b;
    logic        in_valid0, in_valid1;
    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic        out_ready0, out_ready1;
    logic [63:0] diff0, diff1;
    logic        borrow0, borrow1;
`ifdef SUB_OVF_EN
    logic        ovf0, ovf1;
`endif

    chunked_sub_unit #(.W(64), .CHUNK(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready0),
        .diff(diff0), .borrow(borrow0)
`ifdef SUB_OVF_EN
        , .ovf(ovf0)
`endif
    );

    chunked_sub_unit #(.W(64), .CHUNK(64)) u_dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .borrow(borrow1)
`ifdef SUB_OVF_EN
        , .ovf(ovf1)
`endif
    );

    typedef struct packed {
        logic [63:0] diff;
        logic        borrow;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   applied;
    int   miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [63:0] aa, input logic [63:0] bb);
        exp_t e;
        e.diff   = aa - bb;
        e.borrow = (aa < bb);
        e.ovf    = (aa[63] != bb[63]) && (e.diff[63] != aa[63]);
        return e;
    endfunction

    function automatic logic obs_ovf(input bit sel);
`ifdef SUB_OVF_EN
        return sel ? ovf1 : ovf0;
`else
        return 1'b0 ^ sel ^ sel;
`endif
    endfunction

    // Drive one operation, wait for the result, compare against the scoreboard, then drain it.
    task automatic run_op(input bit sel, input logic [63:0] aa, input logic [63:0] bb, input string name);
        exp_t e;
        int   lat;
        int   want_lat;
        sb.push_back(model(aa, bb));
        want_lat = sel ? 1 : 4;
        a = aa;
        b = bb;
        if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        lat = 0;
        while (!(sel ? out_valid1 : out_valid0) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        applied++;
        if (lat != want_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, want_lat);
        end
        applied++;
        if ((sel ? diff1 : diff0) !== e.diff) begin
            miscompares++;
            $display("FAIL %s diff: got %h, expected %h", name, sel ? diff1 : diff0, e.diff);
        end
        applied++;
        if ((sel ? borrow1 : borrow0) !== e.borrow) begin
            miscompares++;
            $display("FAIL %s borrow: got %b, expected %b", name, sel ? borrow1 : borrow0, e.borrow);
        end
`ifdef SUB_OVF_EN
        applied++;
        if (obs_ovf(sel) !== e.ovf) begin
            miscompares++;
            $display("FAIL %s ovf: got %b, expected %b", name, obs_ovf(sel), e.ovf);
        end
`endif
        if (sel) out_ready1 = 1'b1; else out_ready0 = 1'b1;
        @(posedge clk); #1;
        out_ready0 = 1'b0;
        out_ready1 = 1'b0;
        applied++;
        if ((sel ? in_ready1 : in_ready0) !== 1'b1 || (sel ? out_valid1 : out_valid0) !== 1'b0) begin
            miscompares++;
            $display("FAIL %s release: in_ready=%b out_valid=%b, expected 1/0", name,
                     sel ? in_ready1 : in_ready0, sel ? out_valid1 : out_valid0);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        applied++;
        if ({in_ready0, out_valid0, diff0, borrow0, obs_ovf(0)} !== {1'b1, 1'b0, 64'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_chunked: in_ready=%b out_valid=%b diff=%h borrow=%b, expected 1 0 0 0",
                     in_ready0, out_valid0, diff0, borrow0);
        end
        applied++;
        if ({in_ready1, out_valid1, diff1, borrow1, obs_ovf(1)} !== {1'b1, 1'b0, 64'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_full: in_ready=%b out_valid=%b diff=%h borrow=%b, expected 1 0 0 0",
                     in_ready1, out_valid1, diff1, borrow1);
        end
    endtask

    task automatic test_basic;
        run_op(0, 64'h0000_0001_0000_0000, 64'd1, "basic_ripple");
        run_op(0, 64'd0, 64'd1, "underflow");
        run_op(0, 64'h8000_0000_0000_0000, 64'd1, "signed_ovf");
        run_op(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "signed_ovf_neg");
    endtask

    task automatic test_backpressure;
        exp_t        e;
        logic [63:0] held_diff;
        logic        held_borrow;
        int          lat;
        e = model(64'h1234_5678_0000_0000, 64'h0000_0000_0000_00FF);
        sb.push_back(e);
        a = 64'h1234_5678_0000_0000;
        b = 64'h0000_0000_0000_00FF;
        in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        applied++;
        if (diff0 !== e.diff || borrow0 !== e.borrow) begin
            miscompares++;
            $display("FAIL bp_result: got %h/%b, expected %h/%b", diff0, borrow0, e.diff, e.borrow);
        end
        held_diff   = diff0;
        held_borrow = borrow0;
        // A competing request while the result is held must not be taken.
        in_valid0 = 1'b1;
        a = 64'd999;
        b = 64'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            applied++;
            if (diff0 !== held_diff || borrow0 !== held_borrow || in_ready0 !== 1'b0 || out_valid0 !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d: diff=%h borrow=%b in_ready=%b out_valid=%b, expected %h %b 0 1",
                         i, diff0, borrow0, in_ready0, out_valid0, held_diff, held_borrow);
            end
        end
        in_valid0  = 1'b0;
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        out_ready0 = 1'b0;
        applied++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, expected 1/0", in_ready0, out_valid0);
        end
    endtask

    task automatic test_back_to_back;
        run_op(0, 64'd5, 64'd3, "b2b_first");
        run_op(0, 64'd3, 64'd5, "b2b_second");
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        a = 64'h1234_5678_9ABC_DEF0;
        b = 64'd1;
        in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        applied++;
        if ({in_ready0, out_valid0, diff0, borrow0, obs_ovf(0)} !== {1'b1, 1'b0, 64'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b diff=%h borrow=%b, expected 1 0 0 0",
                     in_ready0, out_valid0, diff0, borrow0);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid0) seen = 1'b1;
        end
        applied++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_no_pulse: out_valid seen=%b, expected 0", seen);
        end
        run_op(0, 64'd10, 64'd10, "after_reset");
    endtask

    task automatic test_full_width;
        run_op(1, 64'd100, 64'd58, "full_width");
        run_op(1, 64'd0, 64'd1, "full_width_underflow");
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            run_op(i[0], {$urandom, $urandom}, {$urandom, $urandom}, "random");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        applied     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid0   = 1'b0;
        in_valid1   = 1'b0;
        out_ready0  = 1'b0;
        out_ready1  = 1'b0;
        a           = '0;
        b           = '0;
        test_reset;
        test_basic;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_run;
        test_full_width;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
